// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
//   Shared definitions for the sequential binary-to-BCD converter:
//   - FSM state encoding (IDLE / SHIFT / DONE, 2 bits)
//   - BCD digit width and the add-3 cell constants
//   - a reference helper that applies the add-3 rule to one digit
// -----------------------------------------------------------------------------
package bcd_pkg;

    // Converter control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } bcd_state_e;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ_ADD    = 3;
    localparam int BCD_DIGIT_MAX  = 9;

    // Add-3 rule for a single digit: 0-4 pass, 5-9 get +3, 10-15 are not
    // legal BCD and collapse to 0 so a corrupted digit cannot propagate a
    // plausible-looking value.
    function automatic logic [BCD_DIGIT_W-1:0] bcd_adj3_f(
        input logic [BCD_DIGIT_W-1:0] digit
    );
        logic [BCD_DIGIT_W-1:0] res;
        if (digit < BCD_DIGIT_W'(BCD_ADJ_THRESH)) begin
            res = digit;
        end else if (digit <= BCD_DIGIT_W'(BCD_DIGIT_MAX)) begin
            res = digit + BCD_DIGIT_W'(BCD_ADJ_ADD);
        end else begin
            res = {BCD_DIGIT_W{1'b0}};
        end
        return res;
    endfunction

endpackage : bcd_pkg

// File: rtl/bcd_adj3.sv
// -----------------------------------------------------------------------------
// bcd_adj3
//   Combinational add-3 digit cell used by the double-dabble adjust step.
//   Ports:
//     digit     in   4   one BCD digit before adjustment
//     adjusted  out  4   digit after the add-3 rule
//   Mapping: 0-4 -> unchanged, 5-9 -> +3, 10-15 -> 0.
// -----------------------------------------------------------------------------
module bcd_adj3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    logic [BCD_DIGIT_W-1:0] adj_s;

    // Digit adjust: explicit case keeps every code point accounted for
    always_comb begin
        adj_s = {BCD_DIGIT_W{1'b0}};
        case (digit)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: adj_s = digit;
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9: adj_s = digit + BCD_DIGIT_W'(BCD_ADJ_ADD);
            default:                      adj_s = {BCD_DIGIT_W{1'b0}};
        endcase
    end

    assign adjusted = adj_s;

endmodule : bcd_adj3

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter feeding
//   the pump display 7-segment decode. One conversion at a time through a
//   start/busy/done handshake; one SHIFT cycle per input bit.
//
//   Parameters:
//     BIN_W   width of bin, also the number of SHIFT cycles (default 8)
//     DIGITS  number of BCD digits produced (default 3)
//
//   Ports:
//     clk     in   1          rising-edge clock
//     rst_n   in   1          synchronous active-low reset
//     start   in   1          conversion request, honoured in IDLE or DONE only
//     bin     in   BIN_W      value to convert, captured on an accepted start
//     busy    out  1          high while shifting
//     done    out  1          one-cycle pulse; bcd valid from this cycle on
//     bcd     out  4*DIGITS   packed result, digit 0 in bcd[3:0]
//     ovf     out  1          only when BCD_OVF_EN is defined
//
//   Configuration macro:
//     BCD_OVF_EN  adds the ovf port and the sticky truncation flag. Without it
//                 values above 10^DIGITS-1 wrap silently (bcd = bin mod 10^DIGITS).
//
//   Timing: start accepted at edge N -> busy for cycles N+1..N+BIN_W,
//   done and new bcd in cycle N+BIN_W+1. A start held high in DONE restarts
//   immediately, giving one result every BIN_W+1 clocks.
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
)
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [BIN_W-1:0]            bin,
    output logic                        busy,
    output logic                        done,
`ifdef BCD_OVF_EN
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                        ovf
`else
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
`endif
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CAT_W = BCD_W + BIN_W;
    // A one-bit input still needs a one-bit counter
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    bcd_state_e         state_r;
    logic [BIN_W-1:0]   sh_bin_r;
    logic [BCD_W-1:0]   sh_bcd_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [BCD_W-1:0]   bcd_r;

    logic [BCD_W-1:0]   adj_s;
    logic [CAT_W-1:0]   shifted_s;
    logic [BCD_W-1:0]   next_bcd_s;
    logic [BIN_W-1:0]   next_bin_s;
    logic               carry_s;

`ifdef BCD_OVF_EN
    logic               ovf_flag_r;
    logic               ovf_r;
`endif

    // One add-3 cell per digit of the working BCD register
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_adj3 u_adj (
                .digit    (sh_bcd_r[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .adjusted (adj_s[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Shift step: the adjusted BCD and remaining binary move left as one word;
    // the bit leaving the top digit is what truncation discards.
    always_comb begin
        shifted_s  = {adj_s, sh_bin_r} << 1;
        next_bcd_s = shifted_s[CAT_W-1 -: BCD_W];
        next_bin_s = shifted_s[BIN_W-1:0];
        carry_s    = adj_s[BCD_W-1];
    end

    // Converter FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            sh_bin_r   <= {BIN_W{1'b0}};
            sh_bcd_r   <= {BCD_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bcd_r      <= {BCD_W{1'b0}};
`ifdef BCD_OVF_EN
            ovf_flag_r <= 1'b0;
            ovf_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                // IDLE and DONE accept a request identically so a held start
                // runs conversions back-to-back without an idle gap.
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r    <= ST_SHIFT;
                        sh_bin_r   <= bin;
                        sh_bcd_r   <= {BCD_W{1'b0}};
                        cnt_r      <= {CNT_W{1'b0}};
                        busy_r     <= 1'b1;
`ifdef BCD_OVF_EN
                        ovf_flag_r <= 1'b0;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    sh_bin_r   <= next_bin_s;
                    sh_bcd_r   <= next_bcd_s;
                    cnt_r      <= cnt_r + CNT_W'(1);
`ifdef BCD_OVF_EN
                    ovf_flag_r <= ovf_flag_r | carry_s;
`endif
                    // The last shift lands directly in the output register so
                    // done and the new bcd appear in the same cycle.
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        bcd_r   <= next_bcd_s;
`ifdef BCD_OVF_EN
                        ovf_r   <= ovf_flag_r | carry_s;
`endif
                    end else begin
                        state_r <= ST_SHIFT;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to a quiet IDLE
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign bcd  = bcd_r;

`ifdef BCD_OVF_EN
    assign ovf = ovf_r;
`else
    // Only the top bit is used for overflow tracking; without it the carry
    // is intentionally discarded.
    logic unused_carry_s;
    assign unused_carry_s = carry_s;
`endif

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
//   Directed self-checking bench for bin2bcd_seq. A 3-digit instance is the
//   main target; a 2-digit instance runs in lockstep on the same stimulus to
//   cover truncation (and ovf when BCD_OVF_EN is defined).
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic        busy2;
    logic        done2;
    logic [7:0]  bcd2;
    logic        ovf2;

    int n_cmp;
    int n_bad;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

`ifdef BCD_OVF_EN
    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy2),
        .done  (done2),
        .bcd   (bcd2),
        .ovf   (ovf2)
    );
`else
    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy2),
        .done  (done2),
        .bcd   (bcd2)
    );
    assign ovf2 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one conversion from IDLE and records what was observed; callers compare.
    task automatic do_convert(input logic [7:0] v, output logic [11:0] got,
                              output logic [7:0] got2, output logic got_ovf,
                              output int lat, output int bcnt, output bit seen);
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        lat  = 1;
        bcnt = 0;
        seen = 1'b0;
        got  = 12'h000;
        got2 = 8'h00;
        got_ovf = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                got     = bcd;
                got2    = bcd2;
                got_ovf = ovf2;
                seen    = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        bin   = 8'd200;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++;
        if (bcd !== 12'h000) begin n_bad++; $display("FAIL reset_bcd: got %h want 000", bcd); end
        rst_n = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_after_reset: busy=%b done=%b want 0/0", busy, done);
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0]  vals [3] = '{8'd0, 8'd99, 8'd255};
        logic [11:0] exps [3] = '{12'h000, 12'h099, 12'h255};
        logic [11:0] got;
        logic [7:0]  got2;
        logic        gov;
        int lat, bcnt;
        bit seen;
        for (int k = 0; k < 3; k++) begin
            do_convert(vals[k], got, got2, gov, lat, bcnt, seen);
            n_cmp++;
            if (!seen || got !== exps[k]) begin
                n_bad++;
                $display("FAIL basic_bcd[%0d]: got %h seen=%0d want %h", vals[k], got, seen, exps[k]);
            end
            n_cmp++;
            if (lat !== 9) begin n_bad++; $display("FAIL basic_latency[%0d]: got %0d want 9", vals[k], lat); end
            n_cmp++;
            if (bcnt !== 8) begin n_bad++; $display("FAIL basic_busy[%0d]: got %0d want 8", vals[k], bcnt); end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp3;
        logic [7:0]  exp2;
        int gap;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd0;
        for (int v = 0; v < 256; v++) begin
            exp3 = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            exp2 = {4'((v / 10) % 10), 4'(v % 10)};
            seen = 1'b0;
            gap  = 0;
            for (int i = 0; i < 30; i++) begin
                @(posedge clk);
                gap++;
                @(negedge clk);
                if (done) begin seen = 1'b1; break; end
            end
            n_cmp++;
            if (!seen || bcd !== exp3) begin
                n_bad++;
                $display("FAIL b2b_bcd[%0d]: got %h seen=%0d want %h", v, bcd, seen, exp3);
            end
            n_cmp++;
            if (bcd2 !== exp2) begin n_bad++; $display("FAIL b2b_bcd2[%0d]: got %h want %h", v, bcd2, exp2); end
            n_cmp++;
            if (gap !== 9) begin n_bad++; $display("FAIL b2b_spacing[%0d]: got %0d want 9", v, gap); end
            if (v < 255) bin = 8'(v + 1);
            else         start = 1'b0;
        end
    endtask

    task automatic test_ignore_start();
        bit seen;
        int lat;
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd123;
        @(posedge clk);
        lat  = 1;
        seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin seen = 1'b1; break; end
            n_cmp++;
            if (bcd !== 12'h255) begin n_bad++; $display("FAIL hold_bcd[c%0d]: got %h want 255", k, bcd); end
            if (k == 2 || k == 5) begin
                start = 1'b1;
                bin   = 8'd45;
            end
            @(posedge clk);
            lat++;
        end
        n_cmp++;
        if (!seen || bcd !== 12'h123) begin
            n_bad++;
            $display("FAIL ignore_bcd: got %h seen=%0d want 123", bcd, seen);
        end
        n_cmp++;
        if (lat !== 9) begin n_bad++; $display("FAIL ignore_latency: got %0d want 9", lat); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL ignore_not_queued: busy=%b done=%b want 0/0", busy, done);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] got;
        logic [7:0]  got2;
        logic        gov;
        int lat, bcnt;
        bit seen;
        bit saw_done;
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd77;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 4) rst_n = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", done); end
        n_cmp++;
        if (bcd !== 12'h000) begin n_bad++; $display("FAIL midrst_bcd: got %h want 000", bcd); end
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin n_bad++; $display("FAIL midrst_no_done: activity=%b want 0", saw_done); end
        do_convert(8'd137, got, got2, gov, lat, bcnt, seen);
        n_cmp++;
        if (!seen || got !== 12'h137) begin
            n_bad++;
            $display("FAIL midrst_fresh: got %h seen=%0d want 137", got, seen);
        end
    endtask

    task automatic test_ovf();
        logic [11:0] got;
        logic [7:0]  got2;
        logic        gov;
        int lat, bcnt;
        bit seen;
        do_convert(8'd200, got, got2, gov, lat, bcnt, seen);
        n_cmp++;
        if (!seen || got2 !== 8'h00) begin n_bad++; $display("FAIL trunc_200: got %h want 00", got2); end
`ifdef BCD_OVF_EN
        n_cmp++;
        if (gov !== 1'b1) begin n_bad++; $display("FAIL ovf_200: got %b want 1", gov); end
`endif
        do_convert(8'd42, got, got2, gov, lat, bcnt, seen);
        n_cmp++;
        if (!seen || got2 !== 8'h42) begin n_bad++; $display("FAIL trunc_42: got %h want 42", got2); end
`ifdef BCD_OVF_EN
        n_cmp++;
        if (gov !== 1'b0) begin n_bad++; $display("FAIL ovf_42: got %b want 0", gov); end
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        bin   = 8'd0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_ovf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_bin2bcd_seq
